// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - interrupt sequencer: arbitrate, drain, redirect to handler, return on mret.
// Define INT_VECTORED_EN for per-source handler vectors (VEC_BASE + cause*4).
module int_sequencer #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter int          PAUSE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               glb_en,
  input  logic               branch_pending,
  input  logic [31:0]        pc_resume,
  input  logic               mret,
  output logic               int_set_pl_pause,
  output logic               int_flag,
  output logic [31:0]        int_pc,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic [31:0]        epc,
  output logic [4:0]         cause,
  output logic               in_handler
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TAKE,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t             state;
  logic [3:0]         drain_cnt;
  logic [NUM_IRQ-1:0] pending;
  logic [4:0]         win_idx;
  logic               src_live;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [31:0]        take_pc;

  assign pending = irq_in & irq_mask & {NUM_IRQ{glb_en}};

  // Descending scan so the lowest set index is the last assignment to stick.
  always_comb begin
    win_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = 5'(i);
    end
  end

  always_comb begin
    src_live = 1'b0;
    ack_vec  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cause == 5'(i)) begin
        src_live   = pending[i];
        ack_vec[i] = 1'b1;
      end
    end
  end

`ifdef INT_VECTORED_EN
  assign take_pc = VEC_BASE + {25'd0, cause, 2'b00};
`else
  assign take_pc = VEC_BASE;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state            <= S_IDLE;
      drain_cnt        <= 4'd0;
      int_set_pl_pause <= 1'b0;
      int_flag         <= 1'b0;
      int_pc           <= 32'd0;
      int_ack          <= '0;
      epc              <= 32'd0;
      cause            <= 5'd0;
      in_handler       <= 1'b0;
    end else begin
      int_flag <= 1'b0;
      int_ack  <= '0;
      case (state)
        S_IDLE: begin
          // A resolving branch owns the redirect this cycle; pc_resume is not yet final.
          if ((|pending) && !branch_pending) begin
            cause            <= win_idx;
            epc              <= pc_resume;
            drain_cnt        <= 4'(PAUSE_CYCLES - 1);
            int_set_pl_pause <= 1'b1;
            state            <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!src_live) begin
            int_set_pl_pause <= 1'b0;
            state            <= S_IDLE;
          end else if (drain_cnt == 4'd0) begin
            int_set_pl_pause <= 1'b0;
            int_flag         <= 1'b1;
            int_ack          <= ack_vec;
            int_pc           <= take_pc;
            state            <= S_TAKE;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        S_TAKE: begin
          in_handler <= 1'b1;
          state      <= S_HANDLER;
        end
        S_HANDLER: begin
          if (mret) begin
            in_handler <= 1'b0;
            int_flag   <= 1'b1;
            int_pc     <= epc;
            state      <= S_RETURN;
          end
        end
        S_RETURN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - self-checking bench for int_sequencer.
module tb_int_sequencer;

  localparam int          NIRQ  = 8;
  localparam logic [31:0] VBASE = 32'h0000_0100;
  localparam int          PCYC  = 2;

  logic            clk;
  logic            clr_n;
  logic [NIRQ-1:0] irq_in;
  logic [NIRQ-1:0] irq_mask;
  logic            glb_en;
  logic            branch_pending;
  logic [31:0]     pc_resume;
  logic            mret;
  logic            int_set_pl_pause;
  logic            int_flag;
  logic [31:0]     int_pc;
  logic [NIRQ-1:0] int_ack;
  logic [31:0]     epc;
  logic [4:0]      cause;
  logic            in_handler;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_epc;

  int_sequencer #(
    .NUM_IRQ     (NIRQ),
    .VEC_BASE    (VBASE),
    .PAUSE_CYCLES(PCYC)
  ) dut (
    .clk             (clk),
    .clr_n           (clr_n),
    .irq_in          (irq_in),
    .irq_mask        (irq_mask),
    .glb_en          (glb_en),
    .branch_pending  (branch_pending),
    .pc_resume       (pc_resume),
    .mret            (mret),
    .int_set_pl_pause(int_set_pl_pause),
    .int_flag        (int_flag),
    .int_pc          (int_pc),
    .int_ack         (int_ack),
    .epc             (epc),
    .cause           (cause),
    .in_handler      (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [NIRQ-1:0] p);
    for (int i = 0; i < NIRQ; i++) begin
      if (p[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [31:0] handler_pc(input int c);
`ifdef INT_VECTORED_EN
    return VBASE + 32'(c) * 32'd4;
`else
    return VBASE;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pause"}, {31'd0, int_set_pl_pause}, 32'd0);
    chk({tag, "_flag"},  {31'd0, int_flag},         32'd0);
    chk({tag, "_pc"},    int_pc,                    32'd0);
    chk({tag, "_ack"},   {24'd0, int_ack},          32'd0);
    chk({tag, "_epc"},   epc,                       32'd0);
    chk({tag, "_cause"}, {27'd0, cause},            32'd0);
    chk({tag, "_inh"},   {31'd0, in_handler},       32'd0);
  endtask

  // Applies a request from IDLE and follows it to HANDLER entry (or confirms nothing is taken).
  task automatic take(input logic [NIRQ-1:0] irq, input logic [NIRQ-1:0] mask,
                      input logic en, input logic [31:0] pc);
    logic [NIRQ-1:0] pend;
    int              c;
    pend      = irq & mask & {NIRQ{en}};
    irq_in    = irq;
    irq_mask  = mask;
    glb_en    = en;
    pc_resume = pc;
    tick();
    if (pend == '0) begin
      chk("idle_pause", {31'd0, int_set_pl_pause}, 32'd0);
      tick();
      chk("idle_flag", {31'd0, int_flag}, 32'd0);
      chk("idle_inh", {31'd0, in_handler}, 32'd0);
      return;
    end
    c       = lowest(pend);
    exp_epc = pc;
    chk("drain_pause", {31'd0, int_set_pl_pause}, 32'd1);
    chk("drain_epc",   epc,                       pc);
    chk("drain_cause", {27'd0, cause},            32'(c));
    for (int i = 1; i < PCYC; i++) begin
      tick();
      chk("drain_pause_n", {31'd0, int_set_pl_pause}, 32'd1);
      chk("drain_flag_n",  {31'd0, int_flag},         32'd0);
    end
    tick();
    chk("take_flag",  {31'd0, int_flag},         32'd1);
    chk("take_pause", {31'd0, int_set_pl_pause}, 32'd0);
    chk("take_pc",    int_pc,                    handler_pc(c));
    chk("take_ack",   {24'd0, int_ack},          32'd1 << c);
    chk("take_epc",   epc,                       pc);
    tick();
    chk("hdl_inh",  {31'd0, in_handler}, 32'd1);
    chk("hdl_flag", {31'd0, int_flag},   32'd0);
    chk("hdl_ack",  {24'd0, int_ack},    32'd0);
  endtask

  task automatic do_return(input logic [NIRQ-1:0] irq_during);
    irq_in = irq_during;
    mret   = 1'b1;
    tick();
    mret = 1'b0;
    chk("ret_flag", {31'd0, int_flag},   32'd1);
    chk("ret_pc",   int_pc,              exp_epc);
    chk("ret_inh",  {31'd0, in_handler}, 32'd0);
    tick();
    chk("ret_flag_off",  {31'd0, int_flag},         32'd0);
    chk("ret_pause_off", {31'd0, int_set_pl_pause}, 32'd0);
    chk("ret_pc_hold",   int_pc,                    exp_epc);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    exp_epc        = 32'd0;
    clr_n          = 1'b0;
    irq_in         = '0;
    irq_mask       = '0;
    glb_en         = 1'b0;
    branch_pending = 1'b0;
    pc_resume      = 32'd0;
    mret           = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    clr_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Basic take, then return
    take(8'h08, 8'hFF, 1'b1, 32'h40);
    do_return(8'h00);

    // Priority
    take(8'h84, 8'hFF, 1'b1, 32'h1234);
    irq_in = 8'h00;
    do_return(8'h00);

    // Branch block: three cycles of branch_pending hold the request off
    irq_in         = 8'h01;
    irq_mask       = 8'hFF;
    glb_en         = 1'b1;
    pc_resume      = 32'h111;
    branch_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("branch_nopause", {31'd0, int_set_pl_pause}, 32'd0);
    end
    branch_pending = 1'b0;
    take(8'h01, 8'hFF, 1'b1, 32'h200);
    irq_in = 8'h00;
    do_return(8'h00);

    // Abort after the first drain cycle
    irq_in    = 8'h08;
    pc_resume = 32'h300;
    tick();
    chk("abort_pause0", {31'd0, int_set_pl_pause}, 32'd1);
    irq_in = 8'h00;
    tick();
    chk("abort_pause", {31'd0, int_set_pl_pause}, 32'd0);
    chk("abort_flag",  {31'd0, int_flag},         32'd0);
    chk("abort_ack",   {24'd0, int_ack},          32'd0);
    chk("abort_inh",   {31'd0, in_handler},       32'd0);
    chk("abort_epc",   epc,                       32'h300);
    chk("abort_cause", {27'd0, cause},            32'd3);
    tick();
    chk("abort_flag2", {31'd0, int_flag}, 32'd0);

    // mret in IDLE is ignored
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("idle_mret_flag", {31'd0, int_flag},   32'd0);
    chk("idle_mret_inh",  {31'd0, in_handler}, 32'd0);

    // Return with a new request pending; handler is not nested
    take(8'h01, 8'hFF, 1'b1, 32'h40);
    irq_in = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nonest_pause", {31'd0, int_set_pl_pause}, 32'd0);
      chk("nonest_inh",   {31'd0, in_handler},       32'd1);
    end
    do_return(8'h02);
    take(8'h02, 8'hFF, 1'b1, 32'h500);
    chk("ret_next_cause", {27'd0, cause}, 32'd1);
    irq_in = 8'h00;
    do_return(8'h00);

    // Reset during DRAIN
    irq_in    = 8'h20;
    pc_resume = 32'hABC;
    tick();
    chk("rstd_pause_pre", {31'd0, int_set_pl_pause}, 32'd1);
    clr_n = 1'b0;
    #1;
    chk_all_zero("rst_drain");
    irq_in = 8'h00;
    clr_n  = 1'b1;
    tick();
    tick();
    chk_all_zero("rst_drain_after");

    // Reset during HANDLER
    take(8'h10, 8'hFF, 1'b1, 32'hDEAD_BEE0);
    clr_n = 1'b0;
    #1;
    chk_all_zero("rst_hdl");
    irq_in = 8'h00;
    clr_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hdl_idle_pause", {31'd0, int_set_pl_pause}, 32'd0);
      chk("rst_hdl_idle_inh",   {31'd0, in_handler},       32'd0);
    end

    // Randomized requests against the priority/vector model
    for (int n = 0; n < 40; n++) begin
      logic [NIRQ-1:0] r_irq;
      logic [NIRQ-1:0] r_mask;
      logic            r_en;
      logic [31:0]     r_pc;
      r_irq  = NIRQ'($urandom);
      r_mask = NIRQ'($urandom);
      r_en   = ($urandom_range(0, 3) != 0);
      r_pc   = $urandom;
      take(r_irq, r_mask, r_en, r_pc);
      if ((r_irq & r_mask & {NIRQ{r_en}}) != '0) begin
        irq_in = 8'h00;
        do_return(8'h00);
      end else begin
        irq_in = 8'h00;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Interrupt sequencer for the 5-stage pipeline. It arbitrates level-sensitive interrupt requests, drains the pipeline, saves the resume PC and fires the redirect. Its outputs drive `int_set_pl_pause`, `int_flag` and `int_pc` of the pipeline status controller, which sends the PC unit to `nextpc_int`. It also sequences the return from the handler (`mret`) through the same redirect path.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of request lines, 1..32.
- `VEC_BASE`, 32'h0000_0100: handler base address, word aligned.
- `PAUSE_CYCLES`, 2: drain cycles with pipeline paused before redirect, 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: pipeline clock. All state updates on posedge.
- `clr_n` in 1: asynchronous active-low reset.
- `irq_in` in NUM_IRQ: level requests, bit 0 highest priority.
- `irq_mask` in NUM_IRQ: 1 = source enabled.
- `glb_en` in 1: global interrupt enable.
- `branch_pending` in 1: branch resolving in MEM this cycle.
- `pc_resume` in 32: address of oldest uncommitted instruction.
- `mret` in 1: return-from-handler decoded, one-cycle pulse.
- `int_set_pl_pause` out 1: freeze all pipeline stages.
- `int_flag` out 1: one-cycle redirect strobe.
- `int_pc` out 32: redirect target, valid when `int_flag`=1.
- `int_ack` out NUM_IRQ: one-hot acknowledge pulse to the granted source.
- `epc` out 32: saved resume PC.
- `cause` out 5: index of the granted source.
- `in_handler` out 1: handler executing.

## Operation
- `pending = irq_in & irq_mask & {NUM_IRQ{glb_en}}`. Winner is the lowest set index (fixed priority).
- FSM states: IDLE, DRAIN, TAKE, HANDLER, RETURN.
- IDLE:
  - If `pending != 0` and `!branch_pending`: latch winner into `cause`, latch `pc_resume` into `epc`, load drain counter with PAUSE_CYCLES-1, go to DRAIN.
  - If `branch_pending` is set, stay in IDLE so the branch redirect wins and `epc` gets the correct PC.
- DRAIN:
  - `int_set_pl_pause`=1; counter decrements each cycle.
  - If the latched source's bit in `pending` drops, abort to IDLE: no ack, `epc`/`cause` keep their latched values, pause released next cycle.
  - When the counter reaches 0 and there is no abort, go to TAKE.
- TAKE:
  - `int_flag`=1 for one cycle; `int_ack[cause]`=1 for one cycle.
  - `int_pc` = handler address (see Configuration). Go to HANDLER.
- HANDLER:
  - `in_handler`=1. No nesting: requests stay pending and are not taken.
  - `mret` moves to RETURN.
- RETURN: `int_flag`=1 for one cycle, `int_pc`=`epc`, then go to IDLE. A pending request is evaluated in IDLE on the following cycle.
- `mret` outside HANDLER is ignored.
- Arithmetic: all address arithmetic is 32-bit and wraps modulo 2^32. `cause` is zero-extended to 5 bits.

## Timing
- Reset values: state IDLE, all outputs 0 (`int_pc`, `epc`, `cause` = 0), counter 0.
- All outputs are registered; none are combinational from inputs.
- Request latency: request seen in IDLE at edge N gives pause high from N+1 through N+PAUSE_CYCLES, `int_flag`/`int_ack` at N+PAUSE_CYCLES+1, and `in_handler` from N+PAUSE_CYCLES+2.
- `int_set_pl_pause` and `int_flag` are never high in the same cycle.
- `int_pc` holds its last value when `int_flag`=0.
- Return latency: `mret` sampled at edge M gives `int_flag` with `int_pc`=`epc` in cycle M+1; `in_handler` falls at M+1.
- Simultaneous request and `branch_pending` in IDLE: branch wins, request is considered the next cycle.
- Simultaneous `mret` and new request in HANDLER: `mret` wins; the request is serviced from IDLE after RETURN.
- `clr_n` low at any time (mid-DRAIN, mid-HANDLER): immediate return to IDLE with all outputs 0. No ack, no redirect is generated.

## Configuration
- `INT_VECTORED_EN` defined: in TAKE, `int_pc = VEC_BASE + (cause << 2)`.
- `INT_VECTORED_EN` undefined: in TAKE, `int_pc = VEC_BASE` for every source; software reads `cause`.

## Test plan
- Basic take, PAUSE_CYCLES=2, vectored:
  - Stimulus: `irq_in`=8'h08, `irq_mask`=8'hFF, `glb_en`=1, `pc_resume`=32'h40.
  - Required: pause for 2 cycles, then `int_flag`=1 with `int_pc`=32'h10C, `int_ack`=8'h08, `epc`=32'h40, `cause`=3.
- Priority: `irq_in`=8'h84 -> `cause`=2, `int_ack`=8'h04. Non-vectored build -> `int_pc`=32'h100.
- Branch block: `irq_in`=8'h01 with `branch_pending`=1 for 3 cycles -> no pause during those cycles. DRAIN starts the cycle after `branch_pending` falls, and `epc` captures `pc_resume` at that edge.
- Abort: `irq_in` drops after the 1st DRAIN cycle -> back in IDLE, no `int_flag`, `int_ack`=0, `in_handler`=0.
- Return: in HANDLER with `epc`=32'h40, pulse `mret` while `irq_in`=8'h02 -> `int_flag` with `int_pc`=32'h40. The next interrupt is taken afterward with `cause`=1. `mret` pulsed in IDLE -> no effect.
- Reset mid-operation: drop `clr_n` during DRAIN and during HANDLER -> all outputs 0 asynchronously. After release, with `irq_in`=0, stays in IDLE.
